int_mem_rd_resp: RTL

INT_MEM_RD_RESP -- requirements
Module: int_mem_rd_resp

---
 rtl/int_mem_pkg.sv | 27 ++
 rtl/int_mem_rd_resp_if.sv | 64 ++++++
 rtl/int_mem_addr_gen.sv | 51 +++++
 rtl/int_mem_rd_resp.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/int_mem_pkg.sv
// -----------------------------------------------------------------------------
// int_mem_pkg
// Shared encodings for the internal-memory AXI read responder:
//   - AXI burst type encodings (FIXED / INCR / WRAP)
//   - AXI response encodings (OKAY / SLVERR)
//   - FSM state type
//   - wrap_len_ok(): legal beat counts for a WRAP burst (2, 4, 8 or 16 beats)
// -----------------------------------------------------------------------------
package int_mem_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/int_mem_rd_resp_if.sv
// -----------------------------------------------------------------------------
// int_mem_rd_resp_if
// Bundles the AXI read-address channel, the AXI read-data channel and the
// SRAM read port of the internal-memory read responder.
//
// Handshake rule for both AXI channels: a transfer happens on a rising clock
// edge where VALID and READY are both 1. Once VALID is raised the payload is
// held stable until that transfer; VALID never waits for READY.
//
// The SRAM read port has no handshake: MEMRDATA is valid exactly one cycle
// after the cycle in which MEMRDEN is high.
//
// Modports:
//   slave  - the responder (AR*/RREADY/MEMRDATA in, ARREADY/R*/MEMRDEN/MEMADDR out)
//   master - the AXI requester plus SRAM model (the opposite directions)
// -----------------------------------------------------------------------------
interface int_mem_rd_resp_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  localparam int MEM_AW = ADDR_W - $clog2(DATA_W / 8);

  // read address channel
  logic [ID_W-1:0]   ARID;
  logic [ADDR_W-1:0] ARADDR;
  logic [7:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic              ARVALID;
  logic              ARREADY;

  // read data channel
  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  // SRAM read port
  logic              MEMRDEN;
  logic [MEM_AW-1:0] MEMADDR;
  logic [DATA_W-1:0] MEMRDATA;

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY,
    output MEMRDEN, MEMADDR,
    input  MEMRDATA
  );

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY,
    input  MEMRDEN, MEMADDR,
    output MEMRDATA
  );

endinterface

// File: rtl/int_mem_addr_gen.sv
// -----------------------------------------------------------------------------
// int_mem_addr_gen
// Combinational next-beat byte address for an AXI read burst.
//   addr      in  current beat byte address
//   size      in  AxSIZE (step = 1 << size bytes)
//   burst     in  AxBURST
//   len       in  AxLEN, present only when INT_MEM_RD_WRAP_EN is defined
//   next_addr out byte address of the following beat
// FIXED holds the address, INCR adds the step modulo 2^ADDR_W.
// Macro INT_MEM_RD_WRAP_EN adds WRAP: the address wraps inside the aligned
// window of (len+1) << size bytes. Without the macro there is no wrap logic;
// WRAP bursts are rejected upstream and never use this address.
// -----------------------------------------------------------------------------
module int_mem_addr_gen
  import int_mem_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
`ifdef INT_MEM_RD_WRAP_EN
  input  logic [7:0]        len,
`endif
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] step;
`ifdef INT_MEM_RD_WRAP_EN
  logic [ADDR_W-1:0] wrap_mask;
`endif

  always_comb begin
    step      = ADDR_W'(1) << size;
    next_addr = addr + step;
`ifdef INT_MEM_RD_WRAP_EN
    wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
`endif
    if (burst == BURST_FIXED) begin
      next_addr = addr;
    end
`ifdef INT_MEM_RD_WRAP_EN
    else if (burst == BURST_WRAP) begin
      // Window size is a power of two, so the base bits stay fixed and only
      // the offset bits inside the window advance (and roll over).
      next_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
    end
`endif
  end

endmodule

// File: rtl/int_mem_rd_resp.sv
// -----------------------------------------------------------------------------
// int_mem_rd_resp
// AXI read responder in front of a single-port internal SRAM with one cycle
// read latency. One burst is outstanding at a time.
//
// Ports:
//   ACLK       in   clock
//   ARESET     in   synchronous active-high reset
//   bus        slave modport of int_mem_rd_resp_if (AR channel, R channel,
//              SRAM read port MEMRDEN/MEMADDR/MEMRDATA)
//   dbg_state  out  current FSM state (IDLE accepts AR, BURST returns beats)
//
// Optional feature: macro INT_MEM_RD_WRAP_EN enables WRAP bursts. Without it,
// every WRAP burst answers all beats with SLVERR.
//
// Output buffering: a 2-entry FIFO. A slot is claimed when a beat is issued
// (MEMRDEN, or an error beat that needs no SRAM access) and its data is
// filled from MEMRDATA one cycle later. RVALID is "FIFO not empty", and while
// the head slot is still waiting for the SRAM, RDATA is taken straight from
// MEMRDATA. That keeps the first beat two cycles after the AR handshake and
// lets one beat per cycle stream when RREADY stays high. count_q therefore
// already includes the read in flight, so "occupancy + in-flight < 2" is
// simply count_q < 2.
// -----------------------------------------------------------------------------
module int_mem_rd_resp
  import int_mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic             ACLK,
  input  logic             ARESET,
  int_mem_rd_resp_if.slave bus,
  output state_t           dbg_state
);

  localparam int         OFF_W    = $clog2(DATA_W / 8);
  localparam logic [2:0] MAX_SIZE = 3'(OFF_W);

  state_t state_q, state_d;

  // captured burst
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic              err_q;
  logic [8:0]        issue_left_q;  // beats not yet issued
  logic [7:0]        beat_idx_q;    // index of the next beat to issue

  // output FIFO
  logic [DATA_W-1:0] fifo_data_q [2];
  logic [1:0]        fifo_resp_q [2];
  logic              fifo_last_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q;
  logic              inflight_q;       // an SRAM read was issued last cycle
  logic              inflight_slot_q;  // slot waiting for that read data

  logic              ar_hs, ar_err, push, pop, rvalid, rlast;
  logic [ADDR_W-1:0] next_addr;

  assign ar_hs  = bus.ARVALID && (state_q == ST_IDLE);
  assign rvalid = (count_q != 2'd0);
  assign rlast  = rvalid && fifo_last_q[rd_ptr_q];
  assign pop    = rvalid && bus.RREADY;
  assign push   = (state_q == ST_BURST) && (issue_left_q != 9'd0) && (count_q < 2'd2);

  // Reject sizes wider than the data bus, the reserved burst type, and
  // WRAP bursts that are unsupported in this build or have an illegal length.
  always_comb begin
    ar_err = (bus.ARSIZE > MAX_SIZE) || (bus.ARBURST == 2'b11);
`ifdef INT_MEM_RD_WRAP_EN
    if ((bus.ARBURST == BURST_WRAP) && !wrap_len_ok(bus.ARLEN)) begin
      ar_err = 1'b1;
    end
`else
    if (bus.ARBURST == BURST_WRAP) begin
      ar_err = 1'b1;
    end
`endif
  end

  int_mem_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .addr      (addr_q),
    .size      (size_q),
    .burst     (burst_q),
`ifdef INT_MEM_RD_WRAP_EN
    .len       (len_q),
`endif
    .next_addr (next_addr)
  );

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.ARVALID) state_d = ST_BURST;
      ST_BURST: if (pop && rlast) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q         <= ST_IDLE;
      id_q            <= '0;
      addr_q          <= '0;
      len_q           <= '0;
      size_q          <= '0;
      burst_q         <= '0;
      err_q           <= 1'b0;
      issue_left_q    <= '0;
      beat_idx_q      <= '0;
      fifo_data_q[0]  <= '0;
      fifo_data_q[1]  <= '0;
      fifo_resp_q[0]  <= RESP_OKAY;
      fifo_resp_q[1]  <= RESP_OKAY;
      fifo_last_q[0]  <= 1'b0;
      fifo_last_q[1]  <= 1'b0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= '0;
      inflight_q      <= 1'b0;
      inflight_slot_q <= 1'b0;
    end else begin
      state_q <= state_d;

      if (ar_hs) begin
        id_q         <= bus.ARID;
        addr_q       <= bus.ARADDR;
        len_q        <= bus.ARLEN;
        size_q       <= bus.ARSIZE;
        burst_q      <= bus.ARBURST;
        err_q        <= ar_err;
        issue_left_q <= {1'b0, bus.ARLEN} + 9'd1;
        beat_idx_q   <= '0;
      end else if (push) begin
        issue_left_q <= issue_left_q - 9'd1;
        beat_idx_q   <= beat_idx_q + 8'd1;
        addr_q       <= next_addr;
      end

      // Claim a slot; the data arrives next cycle (error beats stay zero).
      if (push) begin
        fifo_data_q[wr_ptr_q] <= '0;
        fifo_resp_q[wr_ptr_q] <= err_q ? RESP_SLVERR : RESP_OKAY;
        fifo_last_q[wr_ptr_q] <= (beat_idx_q == len_q);
        wr_ptr_q              <= ~wr_ptr_q;
      end

      // The slot being filled is always the one claimed last cycle, which
      // differs from the slot claimed this cycle.
      if (inflight_q) begin
        fifo_data_q[inflight_slot_q] <= bus.MEMRDATA;
      end
      inflight_q      <= push && !err_q;
      inflight_slot_q <= wr_ptr_q;

      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end

      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.ARREADY = (state_q == ST_IDLE);
  assign bus.MEMRDEN = push && !err_q;
  assign bus.MEMADDR = addr_q[ADDR_W-1:OFF_W];

  assign bus.RVALID  = rvalid;
  assign bus.RLAST   = rlast;
  assign bus.RRESP   = rvalid ? fifo_resp_q[rd_ptr_q] : RESP_OKAY;
  assign bus.RID     = id_q;
  assign bus.RDATA   = (inflight_q && (inflight_slot_q == rd_ptr_q)) ? bus.MEMRDATA
                                                                     : fifo_data_q[rd_ptr_q];

  assign dbg_state   = state_q;

endmodule
